seg_scroller_param: RTL and testbench

Parametrised marquee scroller for multi-digit 7-segment displays. It buffers a variable-length message of DW-bit character codes, loaded through a valid/ready write port. It then scrolls the message across DIGITS display slots, one frame per tick_i strobe, and drives the packed code vector consumed by the per-digit decoders. Supported modes: loop or one-shot, left or right scroll direction, and pause.

---
 rtl/seg_scroller_param.sv | 131 +++++++++++++
 tb/tb_seg_scroller_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroller_param.sv
// Marquee scroller for multi-digit 7-segment displays: buffers a message
// written through a valid/ready port and scrolls it one frame per tick.
module seg_scroller_param #(
    parameter int             DIGITS  = 3,
    parameter int             MAX_LEN = 8,
    parameter int             DW      = 4,
    parameter logic [DW-1:0]  BLANK   = '1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick_i,
    input  logic                           wr_valid,
    input  logic [DW-1:0]                  wr_data,
    input  logic                           wr_last,
    output logic                           wr_ready,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           mode_loop,
    input  logic                           dir,
    input  logic                           pause,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_LEN+1)-1:0]   len_o,
    output logic [DIGITS*DW-1:0]           disp
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int FW = $clog2(MAX_LEN + DIGITS + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic [FW-1:0]       f, f_n, f_last;
    logic [LW-1:0]       len;
    logic [IW-1:0]       wr_ptr;
    logic [DW-1:0]       mem [MAX_LEN];
    logic                done_n;
    logic                disp_upd;
    logic [DIGITS*DW-1:0] disp_n;
    logic                wr_fire;
    logic                wr_commit;
    int                  idx;

    assign wr_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign len_o     = len;
    assign wr_fire   = wr_valid && wr_ready;
    assign wr_commit = wr_last || (wr_ptr == IW'(MAX_LEN - 1));

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            len    <= '0;
        end else if (wr_fire) begin
            if (wr_commit) begin
                len    <= LW'(wr_ptr) + LW'(1);
                wr_ptr <= '0;
            end else begin
                wr_ptr <= wr_ptr + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            f     <= '0;
            done  <= 1'b0;
            disp  <= {DIGITS{BLANK}};
        end else begin
            state <= state_n;
            f     <= f_n;
            done  <= done_n;
            if (disp_upd) begin
                disp <= disp_n;
            end
        end
    end

    always_comb begin
        state_n  = state;
        f_n      = f;
        done_n   = 1'b0;
        f_last   = FW'(len) + FW'(DIGITS);
        disp_upd = 1'b0;
        if (stop) begin
            state_n  = IDLE;
            f_n      = '0;
            disp_upd = 1'b1;
        end else if (start && (state == RUN || len != '0)) begin
            state_n  = RUN;
            f_n      = '0;
            disp_upd = 1'b1;
        end else if (state == RUN && tick_i && !pause) begin
            disp_upd = 1'b1;
            if (f < f_last) begin
                f_n = f + FW'(1);
            end else if (mode_loop) begin
                f_n = '0;
            end else begin
                state_n = IDLE;
                f_n     = '0;
                done_n  = 1'b1;
            end
        end
    end

    // Display is built from the next-state frame so it lands on the same edge as the advance.
    always_comb begin
        disp_n = {DIGITS{BLANK}};
        idx    = 0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (dir) begin
                idx = int'(len) - int'(f_n) + int'(k);
            end else begin
                idx = int'(f_n) - DIGITS + int'(k);
            end
            if (state_n == RUN && idx >= 0 && idx < int'(len)) begin
                disp_n[(DIGITS-k)*DW-1 -: DW] = mem[idx[IW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_seg_scroller_param.sv
// Directed self-checking bench for seg_scroller_param (3 digits, 8-deep buffer).
module tb_seg_scroller_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_i = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_data = '0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode_loop = 1'b0;
    logic        dir = 1'b0;
    logic        pause = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  len_o;
    logic [11:0] disp;

    int errors = 0;
    int checks = 0;

    logic [11:0] seq_l [7] = '{12'hFFF, 12'hFF1, 12'hF12, 12'h123, 12'h23F, 12'h3FF, 12'hFFF};
    logic [11:0] seq_r [7] = '{12'hFFF, 12'h3FF, 12'h23F, 12'h123, 12'hF12, 12'hFF1, 12'hFFF};
    logic [11:0] seq_2 [6] = '{12'hFFF, 12'hFF8, 12'hF89, 12'h89F, 12'h9FF, 12'hFFF};

    seg_scroller_param #(.DIGITS(3), .MAX_LEN(8), .DW(4), .BLANK(4'hF)) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready), .start(start), .stop(stop),
        .mode_loop(mode_loop), .dir(dir), .pause(pause), .busy(busy), .done(done),
        .len_o(len_o), .disp(disp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] d, input logic last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        step();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic tick();
        tick_i = 1'b1; step(); tick_i = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("rst_disp", 32'(disp), 32'hFFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_len", 32'(len_o), 0);
        rst = 1'b1;
        step();

        wr(4'h1, 1'b0); wr(4'h2, 1'b0);
        chk("partial_len", 32'(len_o), 0);
        wr(4'h3, 1'b1);
        chk("len3", 32'(len_o), 3);

        // one-shot, scroll left
        pulse_start();
        chk("l_f0", 32'(disp), 32'(seq_l[0]));
        chk("l_busy", 32'(busy), 1);
        chk("l_ready", 32'(wr_ready), 0);
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("l_f%0d", i), 32'(disp), 32'(seq_l[i]));
            chk("l_nodone", 32'(done), 0);
        end
        tick();
        chk("l_done", 32'(done), 1);
        chk("l_end_busy", 32'(busy), 0);
        chk("l_end_disp", 32'(disp), 32'hFFF);
        step();
        chk("l_done_once", 32'(done), 0);
        chk("l_len", 32'(len_o), 3);

        // one-shot, scroll right
        dir = 1'b1;
        pulse_start();
        chk("r_f0", 32'(disp), 32'(seq_r[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            chk($sformatf("r_f%0d", i), 32'(disp), 32'(seq_r[i]));
        end
        tick();
        chk("r_done", 32'(done), 1);
        step();
        chk("r_done_once", 32'(done), 0);

        // loop mode, 16 ticks wraps 6 -> 0
        dir = 1'b0; mode_loop = 1'b1;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("loop_t%0d", i), 32'(disp), 32'(seq_l[i % 7]));
            chk("loop_busy", 32'(busy), 1);
            chk("loop_nodone", 32'(done), 0);
        end

        // f=2 now; advance to frame 3, then pause across three ticks
        tick();
        chk("pre_pause", 32'(disp), 32'h123);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("paused", 32'(disp), 32'h123);
        end
        pause = 1'b0;
        step();
        chk("unpause_hold", 32'(disp), 32'h123);
        tick();
        chk("unpause_tick", 32'(disp), 32'h23F);

        // stop beats start and tick
        stop = 1'b1; start = 1'b1; tick_i = 1'b1;
        step();
        stop = 1'b0; start = 1'b0; tick_i = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_disp", 32'(disp), 32'hFFF);
        chk("stop_done", 32'(done), 0);
        step();
        chk("stop_done2", 32'(done), 0);

        // start with tick in the same cycle lands on frame 0
        mode_loop = 1'b0;
        pulse_start(); tick(); tick();
        chk("retrig_pre", 32'(disp), 32'hF12);
        start = 1'b1; tick_i = 1'b1; step(); start = 1'b0; tick_i = 1'b0;
        chk("retrig_f0", 32'(disp), 32'hFFF);
        chk("retrig_busy", 32'(busy), 1);
        chk("retrig_nodone", 32'(done), 0);
        tick();
        chk("retrig_f1", 32'(disp), 32'hFF1);

        // asynchronous reset mid-run
        tick();
        #3 rst = 1'b0;
        #1;
        chk("arst_disp", 32'(disp), 32'hFFF);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_len", 32'(len_o), 0);
        chk("arst_ready", 32'(wr_ready), 1);
        step();
        rst = 1'b1;
        step();
        pulse_start();
        chk("empty_start_busy", 32'(busy), 0);
        chk("empty_start_disp", 32'(disp), 32'hFFF);

        // truncation at MAX_LEN, then new message from the overflow
        for (int i = 0; i < 8; i++) begin
            chk("trunc_ready", 32'(wr_ready), 1);
            wr(4'(i), 1'b0);
        end
        chk("trunc_len8", 32'(len_o), 8);
        wr(4'h8, 1'b0);
        chk("trunc_partial", 32'(len_o), 8);
        chk("trunc_ready9", 32'(wr_ready), 1);
        wr(4'h9, 1'b1);
        chk("trunc_len2", 32'(len_o), 2);
        pulse_start();
        chk("m2_f0", 32'(disp), 32'(seq_2[0]));
        for (int i = 1; i < 6; i++) begin
            tick();
            chk($sformatf("m2_f%0d", i), 32'(disp), 32'(seq_2[i]));
        end
        tick();
        chk("m2_done", 32'(done), 1);
        chk("m2_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
